// File: rtl/uart_tx_serializer_if.sv
// Byte handshake between the upstream sequencer and the UART transmitter.
// The master presents tx_data/tx_valid; the slave answers with tx_ready.
interface uart_tx_serializer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, 8 data bits LSB first, stop bit.
// Bytes arrive on a valid/ready handshake; tx is driven straight from a flop.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit.
//
// state  | meaning
// -------+------------------------------------------------
// IDLE   | line high, ready for a byte
// START  | start bit (low) for CLKS_PER_BIT cycles
// DATA   | 8 data bits, LSB first, CLKS_PER_BIT cycles each
// PARITY | even parity bit (UART_TX_PARITY_EN builds only)
// STOP   | stop bit (high); tx_done on its last cycle
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    uart_tx_serializer_if.slave   up,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             bit_end;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign bit_end     = (baud_q == BAUD_MAX);
    assign up.tx_ready = (state_q == IDLE) && ena;
    assign busy        = (state_q != IDLE);
    assign tx_done     = (state_q == STOP) && bit_end && ena;
    assign tx          = tx_q;

    // State, counters, shift register and the registered line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state logic; with ena low every next value equals the current one.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        if (ena) begin
            if (state_q != IDLE) begin
                baud_d = bit_end ? '0 : baud_q + CNT_W'(1);
            end
            case (state_q)
                IDLE: begin
                    if (up.tx_valid) begin
                        shift_d  = up.tx_data;
                        baud_d   = '0;
                        state_d  = START;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^up.tx_data;
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_d = DATA;
                        bit_d   = 3'd0;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state_d = STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Line level for the upcoming cycle, so tx itself is a plain flop.
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer with CLKS_PER_BIT=4.
// Table of bytes with hand-derived bit order and parity, plus sequences for
// back-to-back frames, ena freeze, ena low in idle and mid-frame reset.
module tb_uart_tx_serializer;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic ena;
    logic tx, busy, tx_done;

    uart_tx_serializer_if u_if ();

    uart_tx_serializer #(.CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .up      (u_if.slave),
        .tx      (tx),
        .busy    (busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change only on negedges, so negedge+2 shows what the next posedge sees.
    int n_acc = 0;
    always @(negedge clk) begin
        #2;
        if (rst_n && u_if.tx_valid && u_if.tx_ready) n_acc++;
    end

    int errors = 0;
    int checks = 0;
    int start_cyc, stop_cyc, done_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // seq holds the data bits in transmission order, first bit in seq[7].
    function automatic logic exp_bit(input logic [7:0] seq, input logic par, input int p);
        if (p == 0) return 1'b0;
        if (p <= 8) return seq[8-p];
        if (NB == 11 && p == 9) return par;
        return 1'b1;
    endfunction

    task automatic run_frame(input logic [7:0] d, input logic [7:0] seq, input logic par,
                             input bit hold, input int ena_at, input int rst_at);
        int   n;
        int   last;
        logic b;
        last = NB * CPB;
        u_if.tx_data  = d;
        u_if.tx_valid = 1'b1;
        n = 0;
        while (!u_if.tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept expected accept of %0h", d);
            u_if.tx_valid = 1'b0;
            return;
        end
        @(negedge clk);
        u_if.tx_data  = ~d;
        u_if.tx_valid = hold;
        for (int c = 1; c <= last; c++) begin
            b = exp_bit(seq, par, (c - 1) / CPB);
            check("tx", tx, b);
            check("tx_done", tx_done, c == last);
            check("busy", busy, 1);
            check("tx_ready", u_if.tx_ready, 0);
            if (c == 1) start_cyc = cyc;
            if (c == (NB - 1) * CPB + 1) stop_cyc = cyc;
            if (c == last) done_cyc = cyc;
            if (c == ena_at) begin
                ena = 1'b0;
                repeat (7) begin
                    @(negedge clk);
                    check("tx_frozen", tx, b);
                    check("done_frozen", tx_done, 0);
                    check("ready_frozen", u_if.tx_ready, 0);
                end
                ena = 1'b1;
            end
            if (c == rst_at) begin
                #1 rst_n = 1'b0;
                #1;
                check("rst_tx", tx, 1);
                check("rst_busy", busy, 0);
                check("rst_done", tx_done, 0);
                check("rst_ready", u_if.tx_ready, 1);
                repeat (3) begin
                    @(negedge clk);
                    check("rst_hold_tx", tx, 1);
                    check("rst_hold_done", tx_done, 0);
                    check("rst_hold_busy", busy, 0);
                end
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
        end
        check("end_ready", u_if.tx_ready, 1);
        check("end_busy", busy, 0);
        check("end_tx", tx, 1);
        check("end_done", tx_done, 0);
        check("frame_len", done_cyc - start_cyc, last - 1 + ((ena_at > 0) ? 7 : 0));
    endtask

    typedef struct {
        logic [7:0] data;
        logic [7:0] seq;
        logic       par;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, s1, st1;

        vecs[0] = '{8'hA5, 8'hA5, 1'b0};
        vecs[1] = '{8'h00, 8'h00, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 1'b0};
        vecs[3] = '{8'h07, 8'hE0, 1'b1};
        vecs[4] = '{8'h03, 8'hC0, 1'b0};
        vecs[5] = '{8'h5B, 8'hDA, 1'b1};
        vecs[6] = '{8'h01, 8'h80, 1'b1};
        vecs[7] = '{8'h3C, 8'h3C, 1'b0};

        ena           = 1'b1;
        rst_n         = 1'b0;
        u_if.tx_valid = 1'b1;
        u_if.tx_data  = 8'hFF;
        @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_ready", u_if.tx_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_done", tx_done, 0);
        repeat (2) @(negedge clk);
        check("reset_hold_tx", tx, 1);
        check("reset_hold_busy", busy, 0);
        u_if.tx_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        a0 = n_acc;
        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i].data, vecs[i].seq, vecs[i].par, 1'b0, 0, 0);
            repeat (2) @(negedge clk);
        end
        check("table_accepts", n_acc - a0, 8);

        // Back-to-back with tx_valid held high across both frames.
        a0 = n_acc;
        run_frame(8'h00, 8'h00, 1'b0, 1'b1, 0, 0);
        s1  = stop_cyc;
        st1 = start_cyc;
        run_frame(8'hFF, 8'hFF, 1'b0, 1'b1, 0, 0);
        u_if.tx_valid = 1'b0;
        check("b2b_gap", start_cyc - s1, CPB + 1);
        check("b2b_period", start_cyc - st1, NB * CPB + 1);
        repeat (2) @(negedge clk);
        check("b2b_accepts", n_acc - a0, 2);

        // ena dropped for 7 cycles in the middle of data bit 3 (cycles 17..20).
        run_frame(8'hA5, 8'hA5, 1'b0, 1'b0, 18, 0);
        repeat (2) @(negedge clk);

        // ena low while idle: no ready, no accept.
        a0            = n_acc;
        ena           = 1'b0;
        u_if.tx_data  = 8'h5B;
        u_if.tx_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("idle_ena_ready", u_if.tx_ready, 0);
            check("idle_ena_busy", busy, 0);
            check("idle_ena_tx", tx, 1);
        end
        u_if.tx_valid = 1'b0;
        ena           = 1'b1;
        @(negedge clk);
        check("idle_ena_accepts", n_acc - a0, 0);

        // Reset in data bit 4, then a clean full frame.
        run_frame(8'h3C, 8'h3C, 1'b0, 1'b0, 0, 22);
        repeat (2) @(negedge clk);
        run_frame(8'h81, 8'h81, 1'b0, 1'b0, 0, 0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
